// File: rtl/alarm_sequencer.sv
// Alarm clock sequencer: rings when the BCD wall time reaches the alarm time,
// with a limited number of snoozes per event, a stop button and ring auto-stop.
module alarm_sequencer #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        one_second,
    input  logic        alarm_enable,
    input  logic [15:0] current_time,
    input  logic [15:0] alarm_time,
    input  logic        snooze_button,
    input  logic        stop_button,
    output logic        sound_alarm,
    output logic        snoozing,
    output logic [2:0]  snooze_left
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RINGING = 2'b01,
        SNOOZE  = 2'b10
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  sec_count;
    logic [8:0]  sec_count_nxt;
    logic [2:0]  snooze_left_nxt;
    logic        match;
    logic        match_d;
    logic        snooze_d;
    logic        stop_d;
    logic        trigger;
    logic        snooze_press;
    logic        stop_press;
    logic        ring_done;
    logic        snooze_done;

    // The trigger fires only on the first clock of a match, so a minute-long
    // match cannot retrigger after a stop or auto-stop.
    assign match        = (current_time == alarm_time);
    assign trigger      = match & ~match_d & alarm_enable;
    assign snooze_press = snooze_button & ~snooze_d;
    assign stop_press   = stop_button & ~stop_d;
    assign ring_done    = one_second && (sec_count == 9'(RING_SECS - 1));
    assign snooze_done  = one_second && (sec_count == 9'(SNOOZE_SECS - 1));

    always_comb begin
        state_nxt       = state;
        sec_count_nxt   = sec_count;
        snooze_left_nxt = snooze_left;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt       = RINGING;
                    sec_count_nxt   = '0;
                    snooze_left_nxt = 3'(MAX_SNOOZE);
                end
            end
            RINGING: begin
                // Priority: enable low, stop, timeout, then snooze.
                if (!alarm_enable || stop_press || ring_done) begin
                    state_nxt     = IDLE;
                    sec_count_nxt = '0;
                end else if (snooze_press && (snooze_left != 3'd0)) begin
                    state_nxt       = SNOOZE;
                    sec_count_nxt   = '0;
                    snooze_left_nxt = snooze_left - 3'd1;
                end else if (one_second) begin
                    sec_count_nxt = sec_count + 9'd1;
                end
            end
            SNOOZE: begin
                if (!alarm_enable || stop_press) begin
                    state_nxt     = IDLE;
                    sec_count_nxt = '0;
                end else if (snooze_done) begin
                    state_nxt     = RINGING;
                    sec_count_nxt = '0;
                end else if (one_second) begin
                    sec_count_nxt = sec_count + 9'd1;
                end
            end
            default: begin
                state_nxt     = IDLE;
                sec_count_nxt = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sec_count   <= '0;
            snooze_left <= '0;
            match_d     <= 1'b0;
            snooze_d    <= 1'b0;
            stop_d      <= 1'b0;
            sound_alarm <= 1'b0;
            snoozing    <= 1'b0;
        end else begin
            state       <= state_nxt;
            sec_count   <= sec_count_nxt;
            snooze_left <= snooze_left_nxt;
            match_d     <= match;
            snooze_d    <= snooze_button;
            stop_d      <= stop_button;
            sound_alarm <= (state_nxt == RINGING);
            snoozing    <= (state_nxt == SNOOZE);
        end
    end

endmodule
